data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Two-port data-memory responder: one shared single-ported DEPTH x 32 array,
// one pending request per CPU port, round-robin service with fixed access latency.
module data_mem_responder #(
  parameter int ACCESS_LAT = 2,
  parameter int DEPTH      = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_read_mem_load,
  input  logic [10:0] p0_mem_radrs_ld,
  input  logic        p0_write_mem,
  input  logic [10:0] p0_mem_wadrs,
  input  logic [31:0] p0_mem_wdata,
  output logic        p0_read_load_valid,
  output logic        p0_write_store_valid,
  output logic [31:0] p0_mem_load_data,
  output logic        p0_proto_err,
  input  logic        p1_read_mem_load,
  input  logic [10:0] p1_mem_radrs_ld,
  input  logic        p1_write_mem,
  input  logic [10:0] p1_mem_wadrs,
  input  logic [31:0] p1_mem_wdata,
  output logic        p1_read_load_valid,
  output logic        p1_write_store_valid,
  output logic [31:0] p1_mem_load_data,
  output logic        p1_proto_err
);

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_LAT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_gnt;
  logic        r_last;
  logic [1:0]  r_pend;
  logic [1:0]  r_pwr;
  logic [10:0] r_paddr [2];
  logic [31:0] r_pdata [2];
  logic [1:0]  r_rvld;
  logic [1:0]  r_wvld;
  logic [1:0]  r_err;
  logic [31:0] r_ldata [2];
  logic [31:0] r_mem [DEPTH];

  logic [1:0]  w_rd;
  logic [1:0]  w_wr;
  logic [1:0]  w_req;
  logic [10:0] w_radr [2];
  logic [10:0] w_wadr [2];
  logic [31:0] w_wdata [2];
  logic        w_complete;
  logic [1:0]  w_clr;
  logic [1:0]  w_busy;
  logic [1:0]  w_take;
  logic        w_gnt_nxt;
  logic [10:0] w_addr;
  logic [31:0] w_wdat;
  logic        w_is_wr;
  logic [31:0] w_mem_rd;

  assign w_rd       = {p1_read_mem_load, p0_read_mem_load};
  assign w_wr       = {p1_write_mem, p0_write_mem};
  assign w_req      = w_rd | w_wr;
  assign w_radr[0]  = p0_mem_radrs_ld;
  assign w_radr[1]  = p1_mem_radrs_ld;
  assign w_wadr[0]  = p0_mem_wadrs;
  assign w_wadr[1]  = p1_mem_wadrs;
  assign w_wdata[0] = p0_mem_wdata;
  assign w_wdata[1] = p1_mem_wdata;

  assign w_complete = (r_state == ACCESS) && (r_cnt == LAST_CNT);
  assign w_clr      = {w_complete & r_gnt, w_complete & ~r_gnt};
  // A port completing this edge is free again, so a fresh pulse there is accepted.
  assign w_busy     = r_pend & ~w_clr;
  assign w_take     = w_req & ~w_busy;
  assign w_gnt_nxt  = (r_pend[0] & r_pend[1]) ? ~r_last : r_pend[1];

  assign w_addr     = r_paddr[r_gnt];
  assign w_wdat     = r_pdata[r_gnt];
  assign w_is_wr    = r_pwr[r_gnt];
  assign w_mem_rd   = r_mem[w_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_pend   <= 2'b00;
      r_pwr    <= 2'b00;
      r_rvld   <= 2'b00;
      r_wvld   <= 2'b00;
      r_err    <= 2'b00;
      r_ldata[0] <= 32'd0;
      r_ldata[1] <= 32'd0;
    end else begin
      r_rvld <= 2'b00;
      r_wvld <= 2'b00;
      r_err  <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (w_req[p] && w_busy[p]) begin
          r_err[p] <= 1'b1;
        end else if (w_req[p]) begin
          r_pend[p] <= 1'b1;
          r_pwr[p]  <= w_wr[p];
          r_err[p]  <= w_rd[p] & w_wr[p];
        end else if (w_clr[p]) begin
          r_pend[p] <= 1'b0;
        end
      end
      case (r_state)
        IDLE: begin
          if (|r_pend) begin
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= 4'd0;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_complete) begin
            r_state <= IDLE;
            r_last  <= r_gnt;
            if (w_is_wr) begin
              r_wvld[r_gnt] <= 1'b1;
            end else begin
              r_rvld[r_gnt]  <= 1'b1;
              r_ldata[r_gnt] <= w_mem_rd;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Request payload and storage carry no reset; the write is masked while reset is high.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (w_take[p]) begin
        r_paddr[p] <= w_wr[p] ? w_wadr[p] : w_radr[p];
        r_pdata[p] <= w_wdata[p];
      end
    end
    if (w_complete && w_is_wr && !reset) begin
      r_mem[w_addr] <= w_wdat;
    end
  end

  assign p0_read_load_valid   = r_rvld[0];
  assign p0_write_store_valid = r_wvld[0];
  assign p0_mem_load_data     = r_ldata[0];
  assign p0_proto_err         = r_err[0];
  assign p1_read_load_valid   = r_rvld[1];
  assign p1_write_store_valid = r_wvld[1];
  assign p1_mem_load_data     = r_ldata[1];
  assign p1_proto_err         = r_err[1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected completions are queued with
// their cycle when a request is driven, and matched when the DUT pulses an output.
module tb_data_mem_responder;

  localparam int LAT  = 2;
  localparam int SLOT = LAT + 1;
  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_ER = 2;

  typedef struct {
    bit          p;
    int          kind;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_read_mem_load, p0_write_mem;
  logic [10:0] p0_mem_radrs_ld, p0_mem_wadrs;
  logic [31:0] p0_mem_wdata;
  logic        p0_read_load_valid, p0_write_store_valid, p0_proto_err;
  logic [31:0] p0_mem_load_data;
  logic        p1_read_mem_load, p1_write_mem;
  logic [10:0] p1_mem_radrs_ld, p1_mem_wadrs;
  logic [31:0] p1_mem_wdata;
  logic        p1_read_load_valid, p1_write_store_valid, p1_proto_err;
  logic [31:0] p1_mem_load_data;

  int  cyc = 0;
  int  n_total = 0;
  int  n_bad = 0;
  int  n_unexp = 0;
  int  e;
  ev_t q[$];

  data_mem_responder #(.ACCESS_LAT(LAT), .DEPTH(2048)) dut (
    .clk(clk), .reset(reset),
    .p0_read_mem_load(p0_read_mem_load), .p0_mem_radrs_ld(p0_mem_radrs_ld),
    .p0_write_mem(p0_write_mem), .p0_mem_wadrs(p0_mem_wadrs), .p0_mem_wdata(p0_mem_wdata),
    .p0_read_load_valid(p0_read_load_valid), .p0_write_store_valid(p0_write_store_valid),
    .p0_mem_load_data(p0_mem_load_data), .p0_proto_err(p0_proto_err),
    .p1_read_mem_load(p1_read_mem_load), .p1_mem_radrs_ld(p1_mem_radrs_ld),
    .p1_write_mem(p1_write_mem), .p1_mem_wadrs(p1_mem_wadrs), .p1_mem_wdata(p1_mem_wdata),
    .p1_read_load_valid(p1_read_load_valid), .p1_write_store_valid(p1_write_store_valid),
    .p1_mem_load_data(p1_mem_load_data), .p1_proto_err(p1_proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input bit p, input int kind, input logic [31:0] d, input int c);
    ev_t ev;
    ev.p = p; ev.kind = kind; ev.data = d; ev.cyc = c;
    q.push_back(ev);
  endtask

  task automatic match(input bit p, input int kind, input logic [31:0] d);
    int    idx;
    string kn;
    idx = -1;
    kn  = (kind == K_RD) ? "rd" : (kind == K_WR) ? "wr" : "err";
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].p == p && q[i].kind == kind) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      n_unexp++;
      $display("unexpected p%0d %s pulse at cycle %0d", p, kn, cyc);
    end else begin
      chk($sformatf("p%0d_%s_cyc", p, kn), cyc, q[idx].cyc);
      if (kind == K_RD) chk($sformatf("p%0d_rd_data", p), d, q[idx].data);
      q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (p0_read_load_valid)   match(1'b0, K_RD, p0_mem_load_data);
    if (p0_write_store_valid) match(1'b0, K_WR, 32'd0);
    if (p0_proto_err)         match(1'b0, K_ER, 32'd0);
    if (p1_read_load_valid)   match(1'b1, K_RD, p1_mem_load_data);
    if (p1_write_store_valid) match(1'b1, K_WR, 32'd0);
    if (p1_proto_err)         match(1'b1, K_ER, 32'd0);
  end

  task automatic clr_req();
    p0_read_mem_load = 1'b0; p0_write_mem = 1'b0;
    p1_read_mem_load = 1'b0; p1_write_mem = 1'b0;
  endtask

  task automatic set_req(input bit p, input bit rd, input bit wr, input logic [10:0] a,
                         input logic [31:0] d);
    if (p == 1'b0) begin
      if (rd) begin p0_read_mem_load = 1'b1; p0_mem_radrs_ld = a; end
      if (wr) begin p0_write_mem = 1'b1; p0_mem_wadrs = a; p0_mem_wdata = d; end
    end else begin
      if (rd) begin p1_read_mem_load = 1'b1; p1_mem_radrs_ld = a; end
      if (wr) begin p1_write_mem = 1'b1; p1_mem_wadrs = a; p1_mem_wdata = d; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    clr_req();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    chk({tag, "_drain"}, q.size(), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_p0_rvld"}, p0_read_load_valid, 1'b0);
    chk({tag, "_p0_wvld"}, p0_write_store_valid, 1'b0);
    chk({tag, "_p0_err"},  p0_proto_err, 1'b0);
    chk({tag, "_p0_ldat"}, p0_mem_load_data, 32'd0);
    chk({tag, "_p1_rvld"}, p1_read_load_valid, 1'b0);
    chk({tag, "_p1_wvld"}, p1_write_store_valid, 1'b0);
    chk({tag, "_p1_err"},  p1_proto_err, 1'b0);
    chk({tag, "_p1_ldat"}, p1_mem_load_data, 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    chk_reset(tag);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    clr_req();
    p0_mem_radrs_ld = '0; p0_mem_wadrs = '0; p0_mem_wdata = '0;
    p1_mem_radrs_ld = '0; p1_mem_wadrs = '0; p1_mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    reset = 1'b0;
    @(negedge clk);

    // store then load on p0, then a p1 store
    e = cyc + 1; push(0, K_WR, 0, e + 1 + LAT);
    set_req(0, 0, 1, 11'h005, 32'hDEADBEEF); tick(); drain("st005");
    e = cyc + 1; push(0, K_RD, 32'hDEADBEEF, e + 1 + LAT);
    set_req(0, 1, 0, 11'h005, 0); tick(); drain("ld005");
    chk("p0_ld_hold", p0_mem_load_data, 32'hDEADBEEF);
    e = cyc + 1; push(1, K_WR, 0, e + 1 + LAT);
    set_req(1, 0, 1, 11'h100, 32'h0BADF00D); tick(); drain("st100");

    // simultaneous loads after reset: p0 first
    pulse_reset("rst1");
    e = cyc + 1;
    push(0, K_RD, 32'hDEADBEEF, e + 1 + LAT);
    push(1, K_RD, 32'h0BADF00D, e + 1 + LAT + SLOT);
    set_req(0, 1, 0, 11'h005, 0); set_req(1, 1, 0, 11'h100, 0); tick(); drain("pair1");
    e = cyc + 1; push(0, K_RD, 32'h0BADF00D, e + 1 + LAT);
    set_req(0, 1, 0, 11'h100, 0); tick(); drain("p0ld100");
    e = cyc + 1;
    push(1, K_RD, 32'hDEADBEEF, e + 1 + LAT);
    push(0, K_RD, 32'h0BADF00D, e + 1 + LAT + SLOT);
    set_req(0, 1, 0, 11'h100, 0); set_req(1, 1, 0, 11'h005, 0); tick(); drain("pair2");

    // same-address store/load race at top address, both grant orders
    e = cyc + 1; push(1, K_RD, 32'hDEADBEEF, e + 1 + LAT);
    set_req(1, 1, 0, 11'h005, 0); tick(); drain("p1ld005");
    e = cyc + 1;
    push(0, K_WR, 0, e + 1 + LAT);
    push(1, K_RD, 32'h1, e + 1 + LAT + SLOT);
    set_req(0, 0, 1, 11'h7FF, 32'h1); set_req(1, 1, 0, 11'h7FF, 0); tick(); drain("race1");
    e = cyc + 1; push(0, K_RD, 32'h1, e + 1 + LAT);
    set_req(0, 1, 0, 11'h7FF, 0); tick(); drain("p0ld7ff");
    e = cyc + 1;
    push(1, K_RD, 32'h1, e + 1 + LAT);
    push(0, K_WR, 0, e + 1 + LAT + SLOT);
    set_req(0, 0, 1, 11'h7FF, 32'h2); set_req(1, 1, 0, 11'h7FF, 0); tick(); drain("race2");
    e = cyc + 1; push(1, K_RD, 32'h2, e + 1 + LAT);
    set_req(1, 1, 0, 11'h7FF, 0); tick(); drain("p1ld7ff");

    // second pulse while pending is dropped
    e = cyc + 1;
    push(0, K_RD, 32'h2, e + 1 + LAT);
    push(0, K_ER, 0, e + 1);
    set_req(0, 1, 0, 11'h7FF, 0); tick();
    set_req(0, 1, 0, 11'h005, 0); tick(); drain("dup");

    // read and write together: write wins, read reported
    e = cyc + 1;
    push(0, K_ER, 0, e);
    push(0, K_WR, 0, e + 1 + LAT);
    set_req(0, 1, 0, 11'h005, 0); set_req(0, 0, 1, 11'h020, 32'h55AA55AA); tick(); drain("rdwr");
    e = cyc + 1; push(0, K_RD, 32'h55AA55AA, e + 1 + LAT);
    set_req(0, 1, 0, 11'h020, 0); tick(); drain("p0ld020");

    // new request on the completion edge is accepted silently
    e = cyc + 1;
    push(1, K_RD, 32'hDEADBEEF, e + 1 + LAT);
    push(1, K_RD, 32'h55AA55AA, e + 1 + LAT + SLOT);
    set_req(1, 1, 0, 11'h005, 0); tick();
    repeat (LAT) @(negedge clk);
    set_req(1, 1, 0, 11'h020, 0); tick(); drain("b2b");
    chk("p1_ld_hold", p1_mem_load_data, 32'h55AA55AA);

    // reset one cycle into an access aborts the store
    e = cyc + 1; push(0, K_WR, 0, e + 1 + LAT);
    set_req(0, 0, 1, 11'h010, 32'hA5A5A5A5); tick(); drain("st010");
    set_req(0, 0, 1, 11'h010, 32'h12345678); tick();
    @(negedge clk);
    pulse_reset("rst2");
    repeat (4) @(negedge clk);
    e = cyc + 1;
    push(0, K_RD, 32'hA5A5A5A5, e + 1 + LAT);
    push(1, K_RD, 32'h2, e + 1 + LAT + SLOT);
    set_req(0, 1, 0, 11'h010, 0); set_req(1, 1, 0, 11'h7FF, 0); tick(); drain("abort");

    // a store never disturbs the port's last load result
    e = cyc + 1; push(0, K_WR, 0, e + 1 + LAT);
    set_req(0, 0, 1, 11'h030, 32'h77); tick(); drain("st030");
    chk("p0_ld_keep", p0_mem_load_data, 32'hA5A5A5A5);

    repeat (3) @(negedge clk);
    chk("unexpected", n_unexp, 32'd0);
    chk("leftover", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
